// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS unified-memory port arbiter.
//   arb_state_e : arbiter FSM encoding. IDLE, FETCH and DATA have fixed codes so that
//                 waveforms and other blocks can decode them directly.
//   *_DEF       : default widths and data-burst limit used by mem_port_arbiter.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_FETCH = 2'b01,
        ARB_DATA  = 2'b10
    } arb_state_e;

    localparam int ADDR_W_DEF         = 32;
    localparam int DATA_W_DEF         = 32;
    localparam int MAX_DATA_BURST_DEF = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Starvation guard for mem_port_arbiter. It is only instantiated when the macro
// ARB_STARVE_GUARD_EN is defined.
// The block counts data grants that are made while a fetch is waiting. A fetch grant
// clears the count. Once the count reaches MAX_DATA_BURST with a fetch still pending,
// force_fetch_o tells the arbiter to grant the fetch ahead of data.
// Ports:
//   clk, rst_n     : clock and asynchronous active-low reset
//   data_grant_i   : the arbiter grants a data access this cycle
//   fetch_grant_i  : the arbiter grants a fetch this cycle
//   if_pending_i   : a fetch request is waiting
//   force_fetch_o  : the next IDLE grant must go to the fetch
module arb_starve_counter #(
    parameter int MAX_DATA_BURST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic data_grant_i,
    input  logic fetch_grant_i,
    input  logic if_pending_i,
    output logic force_fetch_o
);

    localparam int CNT_W = $clog2(MAX_DATA_BURST + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (fetch_grant_i) begin
            cnt_d = '0;
        end else if (data_grant_i && if_pending_i && (cnt_q != CNT_W'(MAX_DATA_BURST))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign force_fetch_o = if_pending_i && (cnt_q == CNT_W'(MAX_DATA_BURST));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one memory port between instruction fetch (IF) and load/store (MEM).
// Data requests win in IDLE because they belong to the older instruction. The arbiter
// latches one transaction at the grant edge and holds it until mem_ack. Every transaction
// is followed by one IDLE cycle. When IFflush hits an in-flight fetch, the memory access
// still completes, but the fetch never raises if_ready.
// Optional feature: define ARB_STARVE_GUARD_EN to stop a data stream from holding off a
// pending fetch for more than MAX_DATA_BURST grants in a row.
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   if_req/if_addr/if_flush             : fetch request, PC, fetch cancel
//   if_rdata/if_ready                   : fetched word, 1-cycle completion
//   dm_read/dm_write/dm_addr/dm_wdata   : load/store request
//   dm_rdata/dm_ready                   : load data, 1-cycle completion
//   mem_req/mem_we/mem_addr/mem_wdata   : request to memory (held until mem_ack)
//   mem_rdata/mem_ack                   : memory response
//   stall_if/stall_mem                  : freeze signals for the hazard unit
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int MAX_DATA_BURST = MAX_DATA_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              flush_pending_q, flush_pending_d;
    logic              data_req;
    logic              force_fetch;

    // When both strobes are set, the request is treated as a store.
    assign data_req = dm_read | dm_write;

`ifdef ARB_STARVE_GUARD_EN
    logic data_grant;
    logic fetch_grant;

    assign data_grant  = (state_q == ARB_IDLE) && (state_d == ARB_DATA);
    assign fetch_grant = (state_q == ARB_IDLE) && (state_d == ARB_FETCH);

    arb_starve_counter #(
        .MAX_DATA_BURST(MAX_DATA_BURST)
    ) u_starve (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_grant_i (data_grant),
        .fetch_grant_i(fetch_grant),
        .if_pending_i (if_req),
        .force_fetch_o(force_fetch)
    );
`else
    assign force_fetch = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        we_d            = we_q;
        flush_pending_d = flush_pending_q;
        case (state_q)
            ARB_IDLE: begin
                if (data_req && !force_fetch) begin
                    state_d = ARB_DATA;
                    addr_d  = dm_addr;
                    wdata_d = dm_wdata;
                    we_d    = dm_write;
                end else if (if_req) begin
                    state_d = ARB_FETCH;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                end
            end
            ARB_FETCH: begin
                if (if_flush) flush_pending_d = 1'b1;
                if (mem_ack) begin
                    state_d         = ARB_IDLE;
                    flush_pending_d = 1'b0;
                end
            end
            ARB_DATA: begin
                if (mem_ack) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ARB_IDLE;
            addr_q          <= '0;
            wdata_q         <= '0;
            we_q            <= 1'b0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            we_q            <= we_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    // mem_req is decoded from the registered state. Asserting reset forces the state
    // to IDLE, so mem_req drops at once without waiting for a clock edge.
    assign mem_req   = (state_q != ARB_IDLE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // A flush that arrives in the same cycle as the ack must still suppress the fetch.
    assign if_ready  = (state_q == ARB_FETCH) && mem_ack && !flush_pending_q && !if_flush;
    assign dm_ready  = (state_q == ARB_DATA) && mem_ack;
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = data_req & ~dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_flush, dm_read, dm_write, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, dm_ready, mem_req, mem_we, stall_if, stall_mem;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 0; if_flush = 0; dm_read = 0; dm_write = 0; mem_ack = 1'b1;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        n_checks++;
        if ({mem_req, mem_we, if_ready, dm_ready} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl got=%b want=0000", {mem_req, mem_we, if_ready, dm_ready});
        end
        n_checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_fields addr=%h wdata=%h want 0", mem_addr, mem_wdata);
        end
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle mem_req=%b want 0", mem_req);
        end
        tick();
    endtask

    // Fetch whose ack arrives in the same cycle as the request.
    task automatic test_fetch_zero_wait();
        if_req = 1; if_addr = 32'h0000_0040;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0 || stall_if !== 1'b1 || if_ready !== 1'b0) begin
            n_fail++; $display("FAIL f0_cyc0 mem_req=%b stall_if=%b if_ready=%b want 0 1 0", mem_req, stall_if, if_ready);
        end
        tick();
        mem_ack = 1; mem_rdata = 32'h8C02_0004;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL f0_req req=%b addr=%h we=%b want 1 40 0", mem_req, mem_addr, mem_we);
        end
        n_checks++;
        if (if_ready !== 1'b1 || if_rdata !== 32'h8C02_0004 || stall_if !== 1'b0) begin
            n_fail++; $display("FAIL f0_ready rdy=%b rdata=%h stall=%b want 1 8c020004 0", if_ready, if_rdata, stall_if);
        end
        tick();
        if_req = 0; mem_ack = 0;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0 || if_ready !== 1'b0) begin
            n_fail++; $display("FAIL f0_idle req=%b rdy=%b want 0 0", mem_req, if_ready);
        end
        tick();
    endtask

    // Fetch and load rise together: the load is served first.
    task automatic test_data_priority();
        if_req = 1; if_addr = 32'h44; dm_read = 1; dm_addr = 32'h100;
        tick();
        mem_ack = 1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        n_checks++;
        if (mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_req !== 1'b1) begin
            n_fail++; $display("FAIL prio_data addr=%h we=%b req=%b want 100 0 1", mem_addr, mem_we, mem_req);
        end
        n_checks++;
        if (dm_ready !== 1'b1 || dm_rdata !== 32'h1111_2222 || if_ready !== 1'b0) begin
            n_fail++; $display("FAIL prio_dready dm=%b rdata=%h if=%b want 1 11112222 0", dm_ready, dm_rdata, if_ready);
        end
        tick();
        dm_read = 0; mem_ack = 0;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0 || stall_if !== 1'b1) begin
            n_fail++; $display("FAIL prio_gap req=%b stall_if=%b want 0 1", mem_req, stall_if);
        end
        tick();
        mem_ack = 1; mem_rdata = 32'h2108_0001;
        @(negedge clk);
        n_checks++;
        if (mem_addr !== 32'h44 || mem_we !== 1'b0 || if_ready !== 1'b1 || if_rdata !== 32'h2108_0001) begin
            n_fail++; $display("FAIL prio_fetch addr=%h we=%b rdy=%b rdata=%h want 44 0 1 21080001", mem_addr, mem_we, if_ready, if_rdata);
        end
        tick();
        if_req = 0; mem_ack = 0;
        tick();
    endtask

    // Store whose ack arrives after three wait cycles.
    task automatic test_store_wait();
        dm_write = 1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
        tick();
        dm_addr = 32'h0; dm_wdata = 32'h0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD_BEEF
                || dm_ready !== 1'b0 || stall_mem !== 1'b1) begin
                n_fail++; $display("FAIL st_wait%0d req=%b we=%b addr=%h wd=%h rdy=%b stall=%b want 1 1 200 deadbeef 0 1",
                                   i, mem_req, mem_we, mem_addr, mem_wdata, dm_ready, stall_mem);
            end
            tick();
        end
        mem_ack = 1;
        @(negedge clk);
        n_checks++;
        if (dm_ready !== 1'b1 || stall_mem !== 1'b0) begin
            n_fail++; $display("FAIL st_ack rdy=%b stall=%b want 1 0", dm_ready, stall_mem);
        end
        tick();
        dm_write = 0;
        @(negedge clk);
        n_checks++;
        if (dm_ready !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL st_after rdy=%b req=%b want 0 0", dm_ready, mem_req);
        end
        mem_ack = 0;
        tick();
    endtask

    // A flush during an in-flight fetch suppresses its completion.
    task automatic test_flush();
        if_req = 1; if_addr = 32'h80;
        tick();
        tick();
        if_flush = 1;
        @(negedge clk);
        n_checks++;
        if (if_ready !== 1'b0 || mem_req !== 1'b1) begin
            n_fail++; $display("FAIL fl_pulse rdy=%b req=%b want 0 1", if_ready, mem_req);
        end
        tick();
        if_flush = 0; if_addr = 32'h90;
        tick();
        mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        n_checks++;
        if (if_ready !== 1'b0 || mem_addr !== 32'h80) begin
            n_fail++; $display("FAIL fl_suppress rdy=%b addr=%h want 0 80", if_ready, mem_addr);
        end
        tick();
        mem_ack = 0;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_fail++; $display("FAIL fl_idle req=%b want 0", mem_req);
        end
        tick();
        mem_ack = 1; mem_rdata = 32'h0800_0010;
        @(negedge clk);
        n_checks++;
        if (if_ready !== 1'b1 || mem_addr !== 32'h90 || if_rdata !== 32'h0800_0010) begin
            n_fail++; $display("FAIL fl_next rdy=%b addr=%h rdata=%h want 1 90 08000010", if_ready, mem_addr, if_rdata);
        end
        tick();
        if_req = 0; mem_ack = 0;
        tick();
    endtask

    // Reset asserted while a load waits for its ack.
    task automatic test_reset_mid();
        dm_read = 1; dm_addr = 32'h300;
        tick();
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
            n_fail++; $display("FAIL rm_busy req=%b addr=%h want 1 300", mem_req, mem_addr);
        end
        tick();
        rst_n = 0;
        mem_ack = 1;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || dm_ready !== 1'b0 || mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL rm_async req=%b rdy=%b addr=%h want 0 0 0", mem_req, dm_ready, mem_addr);
        end
        mem_ack = 0;
        tick();
        rst_n = 1;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_fail++; $display("FAIL rm_idle req=%b want 0", mem_req);
        end
        tick();
        mem_ack = 1; mem_rdata = 32'h0000_0303;
        @(negedge clk);
        n_checks++;
        if (mem_addr !== 32'h300 || dm_ready !== 1'b1 || dm_rdata !== 32'h303) begin
            n_fail++; $display("FAIL rm_regrant addr=%h rdy=%b rdata=%h want 300 1 303", mem_addr, dm_ready, dm_rdata);
        end
        tick();
        dm_read = 0; mem_ack = 0;
        tick();
    endtask

    // Load and fetch held continuously: checks the sequence of grants.
    task automatic test_back_to_back();
        logic [31:0] exp_addr [6];
        int g;
`ifdef ARB_STARVE_GUARD_EN
        exp_addr = '{32'hB0, 32'hB0, 32'hB0, 32'hB0, 32'hA0, 32'hB0};
`else
        exp_addr = '{32'hB0, 32'hB0, 32'hB0, 32'hB0, 32'hB0, 32'hB0};
`endif
        g = 0;
        if_req = 1; if_addr = 32'hA0; dm_read = 1; dm_addr = 32'hB0; mem_ack = 1;
        for (int c = 0; c < 30 && g < 6; c++) begin
            @(negedge clk);
            if (mem_req) begin
                n_checks++;
                if (mem_addr !== exp_addr[g]) begin
                    n_fail++; $display("FAIL b2b_grant%0d addr=%h want %h", g, mem_addr, exp_addr[g]);
                end
                g++;
            end
            tick();
        end
        n_checks++;
        if (g != 6) begin
            n_fail++; $display("FAIL b2b_timeout grants=%0d want 6", g);
        end
        dm_read = 0;
        tick();
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'hA0 || if_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_fetch req=%b addr=%h rdy=%b want 1 a0 1", mem_req, mem_addr, if_ready);
        end
        tick();
        if_req = 0; mem_ack = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch_zero_wait();
        test_data_priority();
        test_store_wait();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
